// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and SCAN helpers for the N-floor elevator controller
package elevator_pkg;

    // Widest floor vector the helpers accept; narrower vectors are zero-extended.
    localparam int MAX_FLOORS = 16;

    typedef logic [MAX_FLOORS-1:0] floor_vec_t;

    typedef enum logic [1:0] {
        MOTOR_OFF  = 2'b00,
        MOTOR_UP   = 2'b10,
        MOTOR_DOWN = 2'b11
    } motor_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        MOVING    = 2'b01,
        DOOR_OPEN = 2'b10
    } state_e;

    // floor is one-hot: floor - 1 sets every bit strictly below the car,
    // so floor | (floor - 1) is "at or below" and its complement is "above".
    function automatic logic any_above(input floor_vec_t req, input floor_vec_t floor);
        return |(req & ~(floor | (floor - floor_vec_t'(1))));
    endfunction

    function automatic logic any_below(input floor_vec_t req, input floor_vec_t floor);
        return |(req & (floor - floor_vec_t'(1)));
    endfunction

endpackage

// File: rtl/elevator_ctrl_n_if.sv
// rtl/elevator_ctrl_n_if.sv - button inputs and car status outputs of the elevator controller
// Signals:
//   inDoorButtons / outDoorButtons : in-car and hall call buttons, level, bit 0 = ground
//   motor                          : 00 off, 10 up, 11 down
//   doorState                      : 1 = door open
//   currentFloor                   : one-hot car position
//   pendingRequests                : latched, unserved calls
//   dirUp                          : SCAN direction, 1 = up
// master drives the buttons (panel / bench), slave is the controller.
interface elevator_ctrl_n_if #(
    parameter int NUM_FLOORS = 4
);
    logic [NUM_FLOORS-1:0] inDoorButtons;
    logic [NUM_FLOORS-1:0] outDoorButtons;
    logic [1:0]            motor;
    logic                  doorState;
    logic [NUM_FLOORS-1:0] currentFloor;
    logic [NUM_FLOORS-1:0] pendingRequests;
    logic                  dirUp;

    modport master (
        output inDoorButtons,
        output outDoorButtons,
        input  motor,
        input  doorState,
        input  currentFloor,
        input  pendingRequests,
        input  dirUp
    );

    modport slave (
        input  inDoorButtons,
        input  outDoorButtons,
        output motor,
        output doorState,
        output currentFloor,
        output pendingRequests,
        output dirUp
    );
endinterface

// File: rtl/elevator_cycle_timer.sv
// rtl/elevator_cycle_timer.sv - loadable down-counter with zero flag for travel and door dwell
// Ports:
//   CLK, RST   : clock, synchronous active-high reset (count -> 0)
//   load       : strobe, count takes load_value next cycle
//   load_value : value loaded on the strobe
//   zero       : count is 0 (counter holds at 0 until reloaded)
module elevator_cycle_timer #(
    parameter int WIDTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/elevator_ctrl_n.sv
// rtl/elevator_ctrl_n.sv - parametrised N-floor SCAN elevator controller
// Ports:
//   CLK, RST : clock, synchronous active-high reset
//   bus      : elevator_ctrl_n_if.slave (buttons in; motor, door, floor, pending, direction out)
// Parameters:
//   NUM_FLOORS    : floors served (2..16), bit 0 = ground
//   TRAVEL_CYCLES : cycles per floor-to-floor hop (>=1)
//   DOOR_CYCLES   : door dwell after a stop (>=1)
module elevator_ctrl_n
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 4,
    parameter int TRAVEL_CYCLES = 2,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic             CLK,
    input  logic             RST,
    elevator_ctrl_n_if.slave bus
);
    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0]      TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]      DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [NUM_FLOORS-1:0] GROUND      = NUM_FLOORS'(1);

    state_e                state_q,  state_d;
    motor_e                motor_q,  motor_d;
    logic                  door_q,   door_d;
    logic                  dir_up_q, dir_up_d;
    logic [NUM_FLOORS-1:0] floor_q,  floor_d;
    logic [NUM_FLOORS-1:0] req_q,    req_d;

    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_load_value;
    logic                  tmr_zero;

    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] arrive_floor;
    logic [NUM_FLOORS-1:0] eval_floor;
    logic [NUM_FLOORS-1:0] eval_req;
    logic                  req_here;
    logic                  req_above;
    logic                  req_below;
    logic                  seek_move;
    logic                  seek_up;

    // One timer serves both travel and door dwell; the state says which it is timing.
    elevator_cycle_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .zero       (tmr_zero)
    );

    assign press = bus.inDoorButtons | bus.outDoorButtons;

    // Floor reached when the current hop completes; guarded so the one-hot
    // position can never shift off either end of the shaft.
    always_comb begin
        arrive_floor = floor_q;
        if (dir_up_q && !floor_q[NUM_FLOORS-1]) begin
            arrive_floor = floor_q << 1;
        end else if (!dir_up_q && !floor_q[0]) begin
            arrive_floor = floor_q >> 1;
        end
    end

    // The SCAN decision is the same in every state; only the floor it is made
    // from (arrival floor while moving) and whether the current floor still
    // counts (already served while the door is open) differ.
    always_comb begin
        eval_floor = floor_q;
        eval_req   = req_q;
        case (state_q)
            MOVING:    eval_floor = arrive_floor;
            DOOR_OPEN: eval_req   = req_q & ~floor_q;
            default:   ;
        endcase
    end

    assign req_here  = |(eval_req & eval_floor);
    assign req_above = any_above(floor_vec_t'(eval_req), floor_vec_t'(eval_floor));
    assign req_below = any_below(floor_vec_t'(eval_req), floor_vec_t'(eval_floor));
    assign seek_move = req_above | req_below;
    // Requests on both sides: keep going the way we were going.
    assign seek_up   = (req_above && req_below) ? dir_up_q : req_above;

    always_comb begin
        state_d        = state_q;
        motor_d        = motor_q;
        door_d         = door_q;
        dir_up_d       = dir_up_q;
        floor_d        = floor_q;
        req_d          = req_q | press;
        tmr_load       = 1'b0;
        tmr_load_value = TRAVEL_LOAD;

        case (state_q)
            IDLE: begin
                if (req_here) begin
                    state_d        = DOOR_OPEN;
                    door_d         = 1'b1;
                    motor_d        = MOTOR_OFF;
                    tmr_load       = 1'b1;
                    tmr_load_value = DOOR_LOAD;
                end else if (seek_move) begin
                    state_d  = MOVING;
                    dir_up_d = seek_up;
                    motor_d  = seek_up ? MOTOR_UP : MOTOR_DOWN;
                    tmr_load = 1'b1;
                end
            end

            MOVING: begin
                if (tmr_zero) begin
                    floor_d = arrive_floor;
                    if (req_here) begin
                        state_d        = DOOR_OPEN;
                        door_d         = 1'b1;
                        motor_d        = MOTOR_OFF;
                        tmr_load       = 1'b1;
                        tmr_load_value = DOOR_LOAD;
                    end else if (seek_move) begin
                        // Continue, or reverse without an intermediate off cycle.
                        dir_up_d = seek_up;
                        motor_d  = seek_up ? MOTOR_UP : MOTOR_DOWN;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        motor_d = MOTOR_OFF;
                    end
                end
            end

            DOOR_OPEN: begin
                // The floor being served is cleared every cycle, so a call at
                // this floor only extends the dwell and never becomes pending.
                req_d = (req_q | press) & ~floor_q;
                if (|(press & floor_q)) begin
                    tmr_load       = 1'b1;
                    tmr_load_value = DOOR_LOAD;
                end else if (tmr_zero) begin
                    door_d = 1'b0;
                    if (seek_move) begin
                        state_d  = MOVING;
                        dir_up_d = seek_up;
                        motor_d  = seek_up ? MOTOR_UP : MOTOR_DOWN;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                motor_d = MOTOR_OFF;
                door_d  = 1'b0;
            end
        endcase

        // Nothing lies beyond either end of the shaft, so pin the direction there.
        if (floor_d[NUM_FLOORS-1]) begin
            dir_up_d = 1'b0;
        end else if (floor_d[0]) begin
            dir_up_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            motor_q  <= MOTOR_OFF;
            door_q   <= 1'b0;
            dir_up_q <= 1'b1;
            floor_q  <= GROUND;
            req_q    <= '0;
        end else begin
            state_q  <= state_d;
            motor_q  <= motor_d;
            door_q   <= door_d;
            dir_up_q <= dir_up_d;
            floor_q  <= floor_d;
            req_q    <= req_d;
        end
    end

    assign bus.motor           = motor_q;
    assign bus.doorState       = door_q;
    assign bus.currentFloor    = floor_q;
    assign bus.pendingRequests = req_q;
    assign bus.dirUp           = dir_up_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb/tb_elevator_ctrl_n.sv - scenario and randomized bench for elevator_ctrl_n
module tb_elevator_ctrl_n;

    localparam int NF = 4;
    localparam int TC = 2;
    localparam int DC = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    elevator_ctrl_n_if #(.NUM_FLOORS(NF)) bus ();

    elevator_ctrl_n #(
        .NUM_FLOORS    (NF),
        .TRAVEL_CYCLES (TC),
        .DOOR_CYCLES   (DC)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: integer floor, phase (0 idle, 1 moving, 2 door) and the
    // number of cycles left in the phase.
    int            m_floor;
    bit            m_up;
    logic [NF-1:0] m_pend;
    int            m_mode;
    int            m_left;

    task automatic model_reset();
        m_floor = 0; m_up = 1'b1; m_pend = '0; m_mode = 0; m_left = 0;
    endtask

    task automatic decide(input logic [NF-1:0] v, input int f, input bit cur_up,
                          output bit mv, output bit up);
        bit above = 0, below = 0;
        for (int i = 0; i < NF; i++) begin
            if (v[i] && i > f) above = 1;
            if (v[i] && i < f) below = 1;
        end
        mv = above | below;
        up = (above && below) ? cur_up : above;
    endtask

    task automatic model_step(input logic [NF-1:0] p);
        logic [NF-1:0] nxt, look;
        bit mv, up;
        nxt = m_pend | p;
        case (m_mode)
            0: begin
                if (m_pend[m_floor]) begin
                    m_mode = 2; m_left = DC;
                end else begin
                    decide(m_pend, m_floor, m_up, mv, up);
                    if (mv) begin m_mode = 1; m_up = up; m_left = TC; end
                end
            end
            1: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor = m_up ? m_floor + 1 : m_floor - 1;
                    if (m_pend[m_floor]) begin
                        m_mode = 2; m_left = DC;
                    end else begin
                        decide(m_pend, m_floor, m_up, mv, up);
                        if (mv) begin m_up = up; m_left = TC; end
                        else m_mode = 0;
                    end
                end
            end
            default: begin
                nxt[m_floor] = 1'b0;
                if (p[m_floor]) begin
                    m_left = DC;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        look = m_pend;
                        look[m_floor] = 1'b0;
                        decide(look, m_floor, m_up, mv, up);
                        if (mv) begin m_mode = 1; m_up = up; m_left = TC; end
                        else m_mode = 0;
                    end
                end
            end
        endcase
        m_pend = nxt;
        if (m_floor == NF - 1) m_up = 1'b0;
        else if (m_floor == 0) m_up = 1'b1;
    endtask

    // {motor, doorState, currentFloor, pendingRequests, dirUp}
    function automatic logic [11:0] model_vec();
        logic [1:0]    mo;
        logic [NF-1:0] fl;
        mo = (m_mode == 1) ? (m_up ? 2'b10 : 2'b11) : 2'b00;
        fl = '0;
        fl[m_floor] = 1'b1;
        return {mo, (m_mode == 2), fl, m_pend, m_up};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {bus.motor, bus.doorState, bus.currentFloor, bus.pendingRequests, bus.dirUp};
    endfunction

    task automatic tick(input logic [NF-1:0] inb, input logic [NF-1:0] outb);
        bus.inDoorButtons  = inb;
        bus.outDoorButtons = outb;
        @(posedge CLK);
        model_step(inb | outb);
        #1;
        bus.inDoorButtons  = '0;
        bus.outDoorButtons = '0;
    endtask

    task automatic settle();
        for (int i = 0; i < 200; i++) begin
            if (m_mode == 0 && m_pend == '0) break;
            tick('0, '0);
        end
    endtask

    task automatic test_reset();
        bus.inDoorButtons  = '0;
        bus.outDoorButtons = '0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        checks++;
        if (dut_vec() !== 12'b00_0_0001_0000_1) begin
            errors++; $display("FAIL reset_state dut=%b want=%b", dut_vec(), 12'b00_0_0001_0000_1);
        end
        for (int c = 0; c < 3; c++) begin
            tick('0, '0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL reset_idle c%0d dut=%b model=%b", c, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_ground_call();
        int door_first = -1;
        int door_cnt = 0;
        tick('0, 4'b0001);
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL ground_latch dut=%b model=%b", dut_vec(), model_vec());
        end
        for (int c = 1; c <= 10; c++) begin
            tick('0, '0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL ground_c%0d dut=%b model=%b", c, dut_vec(), model_vec());
            end
            if (bus.doorState) begin
                door_cnt++;
                if (door_first < 0) door_first = c;
            end
        end
        checks++;
        if (door_first < 1 || door_first > 2) begin
            errors++; $display("FAIL ground_open_latency got=%0d want=1..2", door_first);
        end
        checks++;
        if (door_cnt !== DC) begin
            errors++; $display("FAIL ground_dwell got=%0d want=%0d", door_cnt, DC);
        end
        checks++;
        if ({bus.pendingRequests, bus.doorState, bus.motor} !== 7'b0000_0_00) begin
            errors++; $display("FAIL ground_final pend=%b door=%b motor=%b want 0000/0/00",
                               bus.pendingRequests, bus.doorState, bus.motor);
        end
    endtask

    task automatic test_travel_up();
        logic [NF-1:0] seen[$];
        logic [NF-1:0] want;
        int up_cnt = 0;
        bit opened = 0;
        seen.push_back(bus.currentFloor);
        tick(4'b1000, '0);
        for (int c = 0; c < 30 && !opened; c++) begin
            tick('0, '0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL travel_c%0d dut=%b model=%b", c, dut_vec(), model_vec());
            end
            if (bus.motor === 2'b10) up_cnt++;
            if (bus.currentFloor !== seen[$]) seen.push_back(bus.currentFloor);
            if (bus.doorState === 1'b1) opened = 1;
        end
        checks++;
        if (!opened || bus.currentFloor !== 4'b1000) begin
            errors++; $display("FAIL travel_stop opened=%0d floor=%b want 1/1000", opened, bus.currentFloor);
        end
        checks++;
        if (up_cnt !== 3 * TC) begin
            errors++; $display("FAIL travel_motor_up_cycles got=%0d want=%0d", up_cnt, 3 * TC);
        end
        checks++;
        if (seen.size() !== NF) begin
            errors++; $display("FAIL travel_steps got=%0d want=%0d", seen.size(), NF);
        end
        for (int i = 0; i < seen.size() && i < NF; i++) begin
            want = '0;
            want[i] = 1'b1;
            checks++;
            if (seen[i] !== want) begin
                errors++; $display("FAIL travel_step%0d got=%b want=%b", i, seen[i], want);
            end
        end
        settle();
    endtask

    task automatic test_scan_reverse();
        logic [NF-1:0] stops[$];
        logic [1:0] prev;
        int viol = 0;
        bit found = 0;
        bit saw_down = 0;
        tick(4'b0001, '0);
        settle();
        tick(4'b1000, '0);
        for (int c = 0; c < 20 && !found; c++) begin
            tick('0, '0);
            if (bus.currentFloor === 4'b0010 && bus.motor === 2'b10) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL scan_reach_floor1 floor=%b motor=%b", bus.currentFloor, bus.motor);
        end
        tick('0, 4'b0001);
        prev = bus.motor;
        for (int c = 0; c < 60; c++) begin
            tick('0, '0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL scan_c%0d dut=%b model=%b", c, dut_vec(), model_vec());
            end
            if (bus.motor === 2'b01 || (bus.doorState && bus.motor !== 2'b00)) viol++;
            if ((prev === 2'b10 && bus.motor === 2'b11) || (prev === 2'b11 && bus.motor === 2'b10)) viol++;
            if (bus.doorState && (stops.size() == 0 || stops[$] !== bus.currentFloor)) stops.push_back(bus.currentFloor);
            if (stops.size() == 1 && bus.motor === 2'b11 && bus.dirUp === 1'b0) saw_down = 1;
            prev = bus.motor;
            if (m_mode == 0 && m_pend == '0 && stops.size() >= 2) break;
        end
        checks++;
        if (stops.size() !== 2 || stops[0] !== 4'b1000 || stops[$] !== 4'b0001) begin
            errors++; $display("FAIL scan_order n=%0d first=%b last=%b want 2/1000/0001",
                               stops.size(), (stops.size() > 0) ? stops[0] : 4'b0,
                               (stops.size() > 0) ? stops[$] : 4'b0);
        end
        checks++;
        if (!saw_down) begin
            errors++; $display("FAIL scan_reverse saw_down=%0d want=1", saw_down);
        end
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL scan_motor_rules violations=%0d want=0", viol);
        end
    endtask

    task automatic test_door_restart();
        bit opened = 0;
        int door_cnt = 0;
        int pend_bad = 0;
        settle();
        tick(4'b0100, '0);
        for (int c = 0; c < 30 && !opened; c++) begin
            tick('0, '0);
            if (bus.doorState === 1'b1) opened = 1;
        end
        checks++;
        if (!opened || bus.currentFloor !== 4'b0100) begin
            errors++; $display("FAIL restart_open opened=%0d floor=%b want 1/0100", opened, bus.currentFloor);
        end
        tick('0, '0);
        tick('0, 4'b0100);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL restart_c%0d dut=%b model=%b", c, dut_vec(), model_vec());
            end
            if (bus.doorState) door_cnt++;
            if (bus.pendingRequests[2]) pend_bad++;
            tick('0, '0);
        end
        checks++;
        if (door_cnt !== DC) begin
            errors++; $display("FAIL restart_dwell got=%0d want=%0d", door_cnt, DC);
        end
        checks++;
        if (pend_bad !== 0) begin
            errors++; $display("FAIL restart_pending_bit2 cycles_set=%0d want=0", pend_bad);
        end
    endtask

    task automatic test_simultaneous();
        logic [NF-1:0] stops[$];
        int dwell[$];
        tick(4'b0001, '0);
        settle();
        tick(4'b0010, 4'b0100);
        checks++;
        if (bus.pendingRequests !== 4'b0110) begin
            errors++; $display("FAIL simul_latch got=%b want=0110", bus.pendingRequests);
        end
        for (int c = 0; c < 40; c++) begin
            tick('0, '0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL simul_c%0d dut=%b model=%b", c, dut_vec(), model_vec());
            end
            if (bus.doorState) begin
                if (stops.size() == 0 || stops[$] !== bus.currentFloor) begin
                    stops.push_back(bus.currentFloor);
                    dwell.push_back(1);
                end else begin
                    dwell[$] = dwell[$] + 1;
                end
            end
            if (m_mode == 0 && m_pend == '0 && stops.size() >= 2) break;
        end
        checks++;
        if (stops.size() !== 2 || stops[0] !== 4'b0010 || stops[$] !== 4'b0100) begin
            errors++; $display("FAIL simul_order n=%0d want 2 stops 0010 then 0100", stops.size());
        end
        for (int i = 0; i < dwell.size(); i++) begin
            checks++;
            if (dwell[i] !== DC) begin
                errors++; $display("FAIL simul_dwell%0d got=%0d want=%0d", i, dwell[i], DC);
            end
        end
    endtask

    task automatic test_random();
        logic [NF-1:0] inb, outb;
        logic [1:0] prev;
        int viol = 0;
        prev = bus.motor;
        for (int c = 0; c < 400; c++) begin
            inb  = ($urandom_range(0, 5) == 0) ? NF'($urandom_range(0, 15)) : '0;
            outb = ($urandom_range(0, 7) == 0) ? NF'($urandom_range(0, 15)) : '0;
            tick(inb, outb);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL random_c%0d dut=%b model=%b", c, dut_vec(), model_vec());
            end
            if (bus.motor === 2'b01 || (bus.doorState && bus.motor !== 2'b00)) viol++;
            if ($countones(bus.currentFloor) != 1) viol++;
            if ((prev === 2'b10 && bus.motor === 2'b11) || (prev === 2'b11 && bus.motor === 2'b10)) viol++;
            prev = bus.motor;
        end
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL random_invariants violations=%0d want=0", viol);
        end
        settle();
    endtask

    task automatic test_reset_mid_travel();
        bit found = 0;
        tick(4'b1000, '0);
        settle();
        tick('0, 4'b0001);
        for (int c = 0; c < 30 && !found; c++) begin
            tick('0, '0);
            if (bus.currentFloor === 4'b0100 && bus.motor === 2'b11) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL rstmid_reach floor=%b motor=%b want 0100/11", bus.currentFloor, bus.motor);
        end
        RST = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (bus.currentFloor !== 4'b0001) begin
            errors++; $display("FAIL rstmid_floor got=%b want=0001", bus.currentFloor);
        end
        checks++;
        if (bus.motor !== 2'b00) begin
            errors++; $display("FAIL rstmid_motor got=%b want=00", bus.motor);
        end
        checks++;
        if (bus.doorState !== 1'b0) begin
            errors++; $display("FAIL rstmid_door got=%b want=0", bus.doorState);
        end
        checks++;
        if (bus.pendingRequests !== 4'b0000) begin
            errors++; $display("FAIL rstmid_pending got=%b want=0000", bus.pendingRequests);
        end
        RST = 1'b0;
        model_reset();
        tick('0, '0);
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL rstmid_after dut=%b model=%b", dut_vec(), model_vec());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ground_call();
        test_travel_up();
        test_scan_reverse();
        test_door_restart();
        test_simultaneous();
        test_random();
        test_reset_mid_travel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
